// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, sequencer states
// and instruction-word field positions.
package cpu_pkg;

  localparam int unsigned IR_W      = 8;
  localparam int unsigned IR_OP_LSB = 5;
  localparam int unsigned IR_OP_W   = 3;
  localparam int unsigned IR_RSV    = 4;
  localparam int unsigned IR_RX_LSB = 2;
  localparam int unsigned IR_RY_LSB = 0;

  localparam logic [IR_OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [IR_OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [IR_OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [IR_OP_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0,
    T1,
    T2,
    T3
  } state_e;

endpackage

// File: rtl/reg_sel_decoder.sv
// Binary-to-one-hot register select decoder with enable; all-zero when disabled.
module reg_sel_decoder #(
  parameter int unsigned NREG = 4
) (
  input  logic                    en_i,
  input  logic [$clog2(NREG)-1:0] idx_i,
  output logic [NREG-1:0]         onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control.sv
// Control sequencer for the simple bus CPU: latches an instruction in T0, then
// drives the register/ALU/data-input bus strobes for one to three execute cycles.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [7:0]      ir_in,
  output logic [NREG-1:0] reg_read,
  output logic [NREG-1:0] reg_write,
  output logic            din_read,
  output logic            a_write,
  output logic            g_write,
  output logic            g_read,
  output logic            alu_sub,
  output logic            ir_load,
  output logic            done
);

  localparam int unsigned IdxW = $clog2(NREG);

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic [IR_OP_W-1:0] op;
  logic [IdxW-1:0]   rx, ry, rd_idx;
  logic              rd_en, wr_en, rd_sel_rx;
  logic              unused_rsvd;

  assign op          = ir_q[IR_OP_LSB +: IR_OP_W];
  assign rx          = ir_q[IR_RX_LSB +: IdxW];
  assign ry          = ir_q[IR_RY_LSB +: IdxW];
  assign unused_rsvd = ir_q[IR_RSV];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir_q <= ir_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    rd_sel_rx = 1'b0;
    din_read  = 1'b0;
    a_write   = 1'b0;
    g_write   = 1'b0;
    g_read    = 1'b0;
    alu_sub   = 1'b0;
    ir_load   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      T0: begin
        // reset forces T0 asynchronously; gating keeps ir_load low while it is held
        ir_load = run & ~reset;
        if (run) begin
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rd_en   = 1'b1;
            wr_en   = 1'b1;
            done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            din_read = 1'b1;
            wr_en    = 1'b1;
            done     = 1'b1;
            state_d  = T0;
          end
          OP_ADD, OP_SUB: begin
            rd_en     = 1'b1;
            rd_sel_rx = 1'b1;
            a_write   = 1'b1;
            state_d   = T2;
          end
          default: begin
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        rd_en   = 1'b1;
        g_write = 1'b1;
        alu_sub = (op == OP_SUB);
        state_d = T3;
      end
      T3: begin
        g_read  = 1'b1;
        wr_en   = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign rd_idx = rd_sel_rx ? rx : ry;

  reg_sel_decoder #(
    .NREG(NREG)
  ) u_read_dec (
    .en_i    (rd_en),
    .idx_i   (rd_idx),
    .onehot_o(reg_read)
  );

  reg_sel_decoder #(
    .NREG(NREG)
  ) u_write_dec (
    .en_i    (wr_en),
    .idx_i   (rx),
    .onehot_o(reg_write)
  );

endmodule

// File: doc/cpu_control.md
# cpu_control

Control sequencer that drives the shared 16-bit tri-state data bus of the simple CPU. It latches an 8-bit instruction, then steps through up to three execute cycles. In each cycle it asserts the per-register `read`/`write` strobes for general registers R0–R3, plus the strobes for the ALU operand register A, the result register G and the external data input. It sits directly upstream of the register file and ALU: every bus transfer in the datapath is caused by one of its outputs.

## Interface
Parameters:
- `NREG`, 4: number of general registers. Strobe vectors are `NREG` wide; register index fields are clog2(`NREG`) bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  start request; sampled only in state T0.
- `ir_in`  in  8  instruction word, captured when `ir_load`=1. Fields: [7:5] opcode, [4] reserved (ignored), [3:2] rx, [1:0] ry.
- `reg_read`  out  NREG  one-hot read strobes for R0..R3 (register drives the bus).
- `reg_write`  out  NREG  one-hot write strobes for R0..R3 (register captures the bus).
- `din_read`  out  1  external data input drives the bus.
- `a_write`  out  1  A captures the bus.
- `g_write`  out  1  G captures the ALU result, A ± bus.
- `g_read`  out  1  G drives the bus.
- `alu_sub`  out  1  ALU subtracts when 1, adds when 0. Meaningful only while `g_write`=1.
- `ir_load`  out  1  instruction register captures `ir_in`.
- `done`  out  1  last cycle of the current instruction.

## Operation
Opcodes:
- MV=000: rx ← ry.
- MVI=001: rx ← data input.
- ADD=010: rx ← rx + ry.
- SUB=011: rx ← rx − ry.
- 100–111 are undefined and execute as NOP.

States are T0 (idle/fetch), T1, T2 and T3. Outputs are combinational from the current state and IR; `ir_load` in T0 is the only output that depends on `run`.

- T0: `ir_load`=`run`. If `run`=1 → T1, otherwise stay in T0. All other strobes are 0.
- T1:
  - MV: `reg_read[ry]`, `reg_write[rx]`, `done` → T0.
  - MVI: `din_read`, `reg_write[rx]`, `done` → T0.
  - ADD/SUB: `reg_read[rx]`, `a_write` → T2.
  - NOP: `done` only → T0.
- T2 (ADD/SUB only): `reg_read[ry]`, `g_write`, `alu_sub`=(op==SUB) → T3.
- T3 (ADD/SUB only): `g_read`, `reg_write[rx]`, `done` → T0.

Invariants:
- At most one bus driver is active in any cycle: the set `reg_read`, `din_read`, `g_read` is zero-hot or one-hot.
- At most one `reg_write` bit is asserted.
- The IR is internal. It changes only on `ir_load`, and `ir_in` changes outside T0 have no effect.
- MV with rx==ry is legal: the same register is read and written in one cycle, and its value is unchanged.

## Timing
- Reset: state=T0 and IR=0x00. All outputs are 0 while `reset` is high, including `ir_load`, which is forced to 0 during reset. The reset is asynchronous, so strobes drop within the same cycle when `reset` rises mid-instruction. The interrupted instruction is abandoned and partial writes already completed stay.
- Latency from `run` sampled high in T0 to `done`:
  - MV, MVI, NOP: 1 cycle after fetch, 2 cycles total.
  - ADD, SUB: 3 cycles after fetch, 4 cycles total.
- Back-to-back: the cycle after `done` is T0. If `run` is still 1, the next instruction is fetched there, giving one fetch cycle between instructions with no extra gap.
- `run` asserted outside T0 is ignored; it is not queued.

## Structure
- Package `cpu_pkg` holds:
  - the opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - the state enum `T0..T3`;
  - the instruction field positions.
- Sub-module `reg_sel_decoder`: a binary-to-one-hot decoder, `NREG` outputs, with an enable input. It is instantiated twice, once for the `reg_read` index (ry, or rx in T1 of ADD/SUB) and once for the `reg_write` index (rx).
- Top level contains the state register, the IR register and the output decode.

## Test plan
- Reset: hold `reset`=1 with `run`=1. Required: all outputs 0 and state stays T0. Release reset with `run`=1. Required: `ir_load`=1 in the first cycle.
- MV R2←R1 (`ir_in`=0x09): in T1, `reg_read`=0010, `reg_write`=0100, `done`=1. The next cycle is T0 with all strobes 0 (`run`=0).
- ADD R0←R0+R3 (`ir_in`=0x43):
  - T1: `reg_read`=0001, `a_write`.
  - T2: `reg_read`=1000, `g_write`, `alu_sub`=0.
  - T3: `g_read`, `reg_write`=0001, `done`.
  - Repeat with SUB (`ir_in`=0x63). Required: `alu_sub`=1 in T2.
- MVI R3 (`ir_in`=0x2C): in T1, `din_read`=1, `reg_write`=1000, `reg_read`=0000, `done`=1. Then hold `run`=1 with a new `ir_in`. Required: the next instruction is fetched in the following cycle.
- Undefined opcode (`ir_in`=0xE5): in T1, `done`=1 and every other strobe is 0. Also: change `ir_in` during T2 of an ADD. Required: no effect on T3 outputs.
- Reset asserted mid-T2 of an ADD. Required: strobes go to 0 immediately, state returns to T0 and `done` is never asserted for that ADD. Scoreboard across all tests: no cycle ever has more than one bus driver asserted.
